// File: rtl/pc_seq_pkg.sv
// Shared types for the picoMIPS program-flow sequencer.
//   op_class_t : decoded instruction class presented by the decoder
//   state_t    : sequencer FSM states
//   branch_taken() : condition evaluation for BEQ/BNE on the ALU zero flag
package pc_seq_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    ALU    = 3'd1,
    BEQ    = 3'd2,
    BNE    = 3'd3,
    JMP    = 3'd4,
    WAITSW = 3'd5,
    HALT   = 3'd6
  } op_class_t;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_RUN     = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // BEQ branches on Z=1, BNE on Z=0; every other class never branches.
  function automatic logic branch_taken(logic [2:0] op, logic z);
    logic taken;
    taken = 1'b0;
    if (op == BEQ) taken = z;
    if (op == BNE) taken = ~z;
    return taken;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the core datapath and the program-flow sequencer.
//   master : core side (drives decoded class, offset, current PC, Z flag)
//   slave  : sequencer side (drives PC controls, target, write qualifier,
//            halt status and retired-instruction count)
interface pc_sequencer_if #(
  parameter int Psize = 6,
  parameter int Osize = 6,
  parameter int Csize = 16
) ();

  logic [2:0]       op_class;
  logic [Osize-1:0] imm;
  logic [Psize-1:0] pc_cur;
  logic             alu_z;

  logic             PCincr;
  logic             PCload;
  logic [Psize-1:0] pc_target;
  logic             reg_we_en;
  logic             halted;
  logic [Csize-1:0] retired;

  modport master (
    output op_class, imm, pc_cur, alu_z,
    input  PCincr, PCload, pc_target, reg_we_en, halted, retired
  );

  modport slave (
    input  op_class, imm, pc_cur, alu_z,
    output PCincr, PCload, pc_target, reg_we_en, halted, retired
  );

endinterface

// File: rtl/pc_sequencer_sync2.sv
// sync2: generic two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   reset : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk edges after d settles
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops use non-blocking assignment so meta and q both sample their
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: picoMIPS program-flow controller.
// Each cycle decides whether the PC increments, loads a branch/jump target
// or holds, handles the sw8 wait-for-input handshake and HALT, qualifies
// register-file writes and counts retired instructions (saturating).
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   sw8   : raw board switch (asynchronous)
//   bus   : op_class/imm/pc_cur/alu_z in; PCincr/PCload/pc_target/
//           reg_we_en/halted/retired out
// Outputs are combinational from state and current inputs; the pc block
// acts on them at the same rising edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Osize = 6,
  parameter int Csize = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw8,
  pc_sequencer_if.slave     bus
);

  state_t           state, state_nx;
  logic             sw_s;
  logic             retire;
  logic [Psize-1:0] rel_target;
  logic [Psize-1:0] abs_target;

  sync2 u_sync_sw8 (
    .clk   (clk),
    .reset (reset),
    .d     (sw8),
    .q     (sw_s)
  );

  // Offset is sign-extended to the PC width; the add wraps modulo 2^Psize.
  assign rel_target = bus.pc_cur + Psize'(signed'(bus.imm));
  assign abs_target = Psize'(bus.imm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_nx;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    bus.PCincr    = 1'b0;
    bus.PCload    = 1'b0;
    bus.pc_target = '0;
    bus.reg_we_en = 1'b0;
    retire        = 1'b0;

    case (state)
      S_BOOT: state_nx = S_RUN;

      S_RUN: begin
        case (bus.op_class)
          BEQ, BNE: begin
            bus.reg_we_en = 1'b1;
            retire        = 1'b1;
            if (branch_taken(bus.op_class, bus.alu_z)) begin
              bus.PCload    = 1'b1;
              bus.pc_target = rel_target;
            end else begin
              bus.PCincr = 1'b1;
            end
          end
          JMP: begin
            bus.PCload    = 1'b1;
            bus.pc_target = abs_target;
            bus.reg_we_en = 1'b1;
            retire        = 1'b1;
          end
          WAITSW: state_nx = S_WAIT_HI;
          HALT:   state_nx = S_HALT;
          // NOP, ALU and any undefined encoding advance like NOP.
          default: begin
            bus.PCincr    = 1'b1;
            bus.reg_we_en = 1'b1;
            retire        = 1'b1;
          end
        endcase
      end

      // A switch already high on entry skips straight to waiting for release.
      S_WAIT_HI: if (sw_s) state_nx = S_WAIT_LO;

      S_WAIT_LO: begin
        if (!sw_s) begin
          bus.PCincr = 1'b1;
          retire     = 1'b1;
          state_nx   = S_RUN;
        end
      end

      S_HALT: state_nx = S_HALT;

      default: state_nx = S_BOOT;
    endcase
  end

  assign bus.halted = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.retired <= '0;
    else if (retire && (bus.retired != '1))
      bus.retired <= bus.retired + Csize'(1);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer with the pc register modelled locally and fed
// back as pc_cur. Stimulus pushes one expected observation per checked
// cycle into a scoreboard queue; a negedge monitor pops and compares.
// A second instance with Csize=4 runs in lockstep to exercise saturation.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  ret4;
    logic [15:0] ret;
    logic [5:0]  pc;
    logic [5:0]  tgt;
    logic        we;
    logic        ld;
    logic        inc;
    logic        hlt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  val;
    obs_t  mask;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       sw8;
  logic [2:0] op;
  logic [5:0] imm;
  logic       z;
  logic [5:0] pc;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer_if #(.Psize(6), .Osize(6), .Csize(16)) m  ();
  pc_sequencer_if #(.Psize(6), .Osize(6), .Csize(4))  m4 ();

  assign m.op_class  = op;
  assign m.imm       = imm;
  assign m.pc_cur    = pc;
  assign m.alu_z     = z;
  assign m4.op_class = op;
  assign m4.imm      = imm;
  assign m4.pc_cur   = pc;
  assign m4.alu_z    = z;

  pc_sequencer #(.Psize(6), .Osize(6), .Csize(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sw8   (sw8),
    .bus   (m.slave)
  );

  pc_sequencer #(.Psize(6), .Osize(6), .Csize(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .sw8   (sw8),
    .bus   (m4.slave)
  );

  // pc block: load wins over increment, async reset to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pc <= '0;
    else if (m.PCload)  pc <= m.pc_target;
    else if (m.PCincr)  pc <= pc + 6'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t obs;
  assign obs = {dut.state, m4.retired, m.retired, pc, m.pc_target,
                m.reg_we_en, m.PCload, m.PCincr, m.halted};

  // Monitor: invariant every cycle, scoreboard entry when one is pending.
  always @(negedge clk) begin
    checks++;
    if (m.PCincr && m.PCload) begin
      failures++;
      $display("FAIL incr_load_excl: PCincr=%0b PCload=%0b, required not both 1",
               m.PCincr, m.PCload);
    end
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("FAIL %s: got st=%0d ret=%0d ret4=%0d pc=%0d tgt=%0d we=%0b ld=%0b inc=%0b hlt=%0b; want st=%0d ret=%0d ret4=%0d pc=%0d tgt=%0d we=%0b ld=%0b inc=%0b hlt=%0b (tgt checked=%0b)",
                 e.name, obs.st, obs.ret, obs.ret4, obs.pc, obs.tgt, obs.we,
                 obs.ld, obs.inc, obs.hlt, e.val.st, e.val.ret, e.val.ret4,
                 e.val.pc, e.val.tgt, e.val.we, e.val.ld, e.val.inc,
                 e.val.hlt, |e.mask.tgt);
      end
    end
  end

  function automatic logic [3:0] sat4(int r);
    return (r > 15) ? 4'd15 : 4'(r);
  endfunction

  // Drive one cycle's inputs just after the rising edge.
  task automatic cyc(logic [2:0] o, logic [5:0] i, logic zz, logic s);
    @(posedge clk);
    #1;
    op  = o;
    imm = i;
    z   = zz;
    sw8 = s;
  endtask

  // Expected observation for an S_RUN cycle.
  task automatic exp_run(string n, logic [5:0] p, logic inc, logic ld,
                         logic [5:0] tgt, logic we, int r);
    exp_t e;
    e.name = n;
    e.val = '0;
    e.mask = '1;
    e.val.st = S_RUN;
    e.val.ret = 16'(r);
    e.val.ret4 = sat4(r);
    e.val.pc = p;
    e.val.tgt = tgt;
    e.val.we = we;
    e.val.ld = ld;
    e.val.inc = inc;
    if (!ld) e.mask.tgt = '0;
    sb.push_back(e);
  endtask

  // Expected observation for boot / wait / halt cycles (no writes, no load).
  task automatic exp_idle(string n, state_t s, logic [5:0] p, logic inc, int r);
    exp_t e;
    e.name = n;
    e.val = '0;
    e.mask = '1;
    e.val.st = s;
    e.val.ret = 16'(r);
    e.val.ret4 = sat4(r);
    e.val.pc = p;
    e.val.inc = inc;
    e.val.hlt = (s == S_HALT);
    if (s != S_BOOT) e.mask.tgt = '0;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    sw8   = 1'b0;
    op    = ALU;
    imm   = '0;
    z     = 1'b0;

    // Reset held for three cycles: everything quiet, PC 0.
    for (int k = 0; k < 3; k++) begin
      cyc(ALU, 6'd0, 1'b0, 1'b0);
      exp_idle("rst_hold", S_BOOT, 6'd0, 1'b0, 0);
    end
    cyc(ALU, 6'd0, 1'b0, 1'b0); reset = 1'b1;
    exp_idle("boot", S_BOOT, 6'd0, 1'b0, 0);
    cyc(ALU, 6'd0, 1'b0, 1'b0);  exp_run("alu0",     6'd0,  1, 0, 6'd0,  1, 0);
    cyc(NOP, 6'd0, 1'b0, 1'b0);  exp_run("nop1",     6'd1,  1, 0, 6'd0,  1, 1);

    // Relative branches from PC 10 with offset -4.
    cyc(JMP, 6'd10, 1'b0, 1'b0); exp_run("jmp10",    6'd2,  0, 1, 6'd10, 1, 2);
    cyc(BEQ, 6'd60, 1'b1, 1'b0); exp_run("beq_t",    6'd10, 0, 1, 6'd6,  1, 3);
    cyc(JMP, 6'd10, 1'b0, 1'b0); exp_run("jmp10b",   6'd6,  0, 1, 6'd10, 1, 4);
    cyc(BEQ, 6'd60, 1'b0, 1'b0); exp_run("beq_nt",   6'd10, 1, 0, 6'd0,  1, 5);
    cyc(JMP, 6'd10, 1'b0, 1'b0); exp_run("jmp10c",   6'd11, 0, 1, 6'd10, 1, 6);
    cyc(BNE, 6'd60, 1'b1, 1'b0); exp_run("bne_nt",   6'd10, 1, 0, 6'd0,  1, 7);
    cyc(BNE, 6'd60, 1'b0, 1'b0); exp_run("bne_t",    6'd11, 0, 1, 6'd7,  1, 8);
    cyc(3'd7, 6'd0, 1'b0, 1'b0); exp_run("undef_op", 6'd7,  1, 0, 6'd0,  1, 9);

    // Wrap, absolute jump, branch-to-self; sw8 raised early to be settled.
    cyc(JMP, 6'd62, 1'b0, 1'b1); exp_run("jmp62",    6'd8,  0, 1, 6'd62, 1, 10);
    cyc(BEQ, 6'd3,  1'b1, 1'b1); exp_run("beq_wrap", 6'd62, 0, 1, 6'd1,  1, 11);
    cyc(JMP, 6'd40, 1'b0, 1'b1); exp_run("jmp40",    6'd1,  0, 1, 6'd40, 1, 12);
    cyc(BEQ, 6'd0,  1'b1, 1'b1); exp_run("beq_self", 6'd40, 0, 1, 6'd40, 1, 13);
    cyc(JMP, 6'd5,  1'b0, 1'b1); exp_run("jmp5",     6'd40, 0, 1, 6'd5,  1, 14);

    // WAITSW with the switch already high: only a release is needed.
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_run("waitsw_a", 6'd5, 0, 0, 6'd0, 0, 15);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("hi_a",      S_WAIT_HI, 6'd5, 1'b0, 15);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("lo_a",      S_WAIT_LO, 6'd5, 1'b0, 15);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("release_a", S_WAIT_LO, 6'd5, 1'b1, 15);

    // WAITSW with the switch low: full press then release.
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_run("waitsw_b", 6'd6, 0, 0, 6'd0, 0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("hi_b0",     S_WAIT_HI, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_idle("hi_b1",     S_WAIT_HI, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_idle("hi_b2",     S_WAIT_HI, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_idle("hi_b3",     S_WAIT_HI, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("lo_b0",     S_WAIT_LO, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("lo_b1",     S_WAIT_LO, 6'd6, 1'b0, 16);
    cyc(WAITSW, 6'd0, 1'b0, 1'b0); exp_idle("release_b", S_WAIT_LO, 6'd6, 1'b1, 16);
    cyc(JMP, 6'd20, 1'b0, 1'b0);   exp_run("jmp20",    6'd7, 0, 1, 6'd20, 1, 17);

    // HALT is absorbing regardless of op or switch activity.
    cyc(HALT, 6'd0, 1'b0, 1'b0);   exp_run("halt_op",  6'd20, 0, 0, 6'd0, 0, 18);
    for (int k = 0; k < 50; k++) begin
      cyc(ALU, 6'd0, k[0], k[1]);
      exp_idle("halted", S_HALT, 6'd20, 1'b0, 18);
    end
    cyc(ALU, 6'd0, 1'b0, 1'b1); reset = 1'b0;
    exp_idle("rst_halt", S_BOOT, 6'd0, 1'b0, 0);
    cyc(ALU, 6'd0, 1'b0, 1'b1); reset = 1'b1;
    exp_idle("boot2", S_BOOT, 6'd0, 1'b0, 0);
    cyc(ALU, 6'd0, 1'b0, 1'b1);    exp_run("alu_b",    6'd0, 1, 0, 6'd0, 1, 0);

    // Reset asserted while waiting for release returns to S_BOOT at once.
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_run("waitsw_c", 6'd1, 0, 0, 6'd0, 0, 1);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_idle("hi_c",    S_WAIT_HI, 6'd1, 1'b0, 1);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); exp_idle("lo_c",    S_WAIT_LO, 6'd1, 1'b0, 1);
    cyc(WAITSW, 6'd0, 1'b0, 1'b1); reset = 1'b0;
    exp_idle("rst_wait", S_BOOT, 6'd0, 1'b0, 0);
    cyc(ALU, 6'd0, 1'b0, 1'b1); reset = 1'b1;
    exp_idle("boot3", S_BOOT, 6'd0, 1'b0, 0);
    cyc(ALU, 6'd0, 1'b0, 1'b1);    exp_run("alu_c",    6'd0, 1, 0, 6'd0, 1, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
